// File: rtl/addsub_seq_if.sv
// Request/response bundle for the chunked adder/subtractor.
// The requester owns start and operands; the unit owns status and result.
interface addsub_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start, a, b, sub, sat,
        input  busy, done, result, cout, ovf, zero, neg
    );

    modport slave (
        input  start, a, b, sub, sat,
        output busy, done, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle two's complement adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Optional signed saturation; status flags are published together with the result.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_seq_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             op_sub;
    logic             op_sat;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] final_res;
    logic             last;
    logic             msb_cin;
    logic             raw_ovf;

    function automatic logic signed [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] raw,
        input logic             ovf_in,
        input logic             sat_en,
        input logic             a_neg
    );
        logic signed [WIDTH-1:0] res;
        if (sat_en && ovf_in)
            res = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            res = raw;
        return res;
    endfunction

    always_comb begin
        base      = int'(idx) * CHUNK;
        a_chunk   = op_a[base +: CHUNK];
        b_chunk   = op_b[base +: CHUNK] ^ {CHUNK{op_sub}};
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        work_next = work;
        work_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        last      = (idx == IW'(N - 1));
        // Carry into the MSB recovered from the MSB's own sum bit.
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        raw_ovf   = msb_cin ^ chunk_sum[CHUNK];
        final_res = saturate(work_next, raw_ovf, op_sat, op_a[WIDTH-1]);
    end

    // Operand and working registers carry no reset; control gates their use.
    always_ff @(posedge clk) begin
        if (state != RUN) begin
            if (bus.start) begin
                op_a <= bus.a;
                op_b <= bus.b;
            end
        end else begin
            work <= work_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            op_sub <= 1'b0;
            op_sat <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        op_sub <= bus.sub;
                        op_sat <= bus.sat;
                        carry  <= bus.sub;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    carry <= chunk_sum[CHUNK];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        result <= final_res;
                        cout   <= chunk_sum[CHUNK];
                        ovf    <= raw_ovf;
                        zero   <= (final_res == '0);
                        neg    <= final_res[WIDTH-1];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.cout   = cout;
    assign bus.ovf    = ovf;
    assign bus.zero   = zero;
    assign bus.neg    = neg;
endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed corner cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_addsub_seq;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic        sub;
    logic        sat;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    addsub_seq_if #(.WIDTH(W)) bus4 ();
    addsub_seq_if #(.WIDTH(W)) bus1 ();
    addsub_seq_if #(.WIDTH(W)) bus16 ();

    assign bus4.start  = start;  assign bus4.a  = a;  assign bus4.b  = b;  assign bus4.sub  = sub;  assign bus4.sat  = sat;
    assign bus1.start  = start;  assign bus1.a  = a;  assign bus1.b  = b;  assign bus1.sub  = sub;  assign bus1.sat  = sat;
    assign bus16.start = start;  assign bus16.a = a;  assign bus16.b = b;  assign bus16.sub = sub;  assign bus16.sat = sat;

    addsub_seq #(.WIDTH(W), .CHUNK(4))  dut     (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    addsub_seq #(.WIDTH(W), .CHUNK(1))  dut_c1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    addsub_seq #(.WIDTH(W), .CHUNK(16)) dut_c16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } res_t;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic st);
        res_t r;
        int sx, sy, sr;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sr = s ? sx - sy : sx + sy;
        r.ovf    = (sr > 32767) || (sr < -32768);
        r.result = 16'(sr);
        r.cout   = s ? (int'(x) >= int'(y)) : ((int'(x) + int'(y)) > 65535);
        if (st && r.ovf)
            r.result = (sx >= 0) ? 16'h7FFF : 16'h8000;
        r.zero = (r.result == 16'h0000);
        r.neg  = r.result[W-1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, ".result"}, 32'(bus4.result), 32'(e.result));
        check({tag, ".cout"},   32'(bus4.cout),   32'(e.cout));
        check({tag, ".ovf"},    32'(bus4.ovf),    32'(e.ovf));
        check({tag, ".zero"},   32'(bus4.zero),   32'(e.zero));
        check({tag, ".neg"},    32'(bus4.neg),    32'(e.neg));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".result"}, 32'(bus4.result), 32'h0);
        check({tag, ".busy"},   32'(bus4.busy),   32'h0);
        check({tag, ".done"},   32'(bus4.done),   32'h0);
        check({tag, ".cout"},   32'(bus4.cout),   32'h0);
        check({tag, ".ovf"},    32'(bus4.ovf),    32'h0);
        check({tag, ".zero"},   32'(bus4.zero),   32'h0);
        check({tag, ".neg"},    32'(bus4.neg),    32'h0);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic st, input bit scramble, input string tag);
        res_t e;
        int lat, bcnt;
        logic [W-1:0] prev;
        e    = model(x, y, s, st);
        prev = bus4.result;
        @(negedge clk);
        a = x; b = y; sub = s; sat = st; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!bus4.done && lat < 40) begin
            if (bus4.busy) bcnt++;
            if (lat == 1) check({tag, ".hold"}, 32'(bus4.result), 32'(prev));
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".busy_cycles"}, 32'(bcnt), 32'd4);
        check_res(tag, e);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t e1, e3;
        int c, d4, d1, d16, lat;
        logic [W-1:0] x, y;
        logic [W-1:0] edge_vals [5];
        edge_vals[0] = 16'h0000; edge_vals[1] = 16'h0001; edge_vals[2] = 16'h7FFF;
        edge_vals[3] = 16'h8000; edge_vals[4] = 16'hFFFF;

        start = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Case 1 on all three chunk sizes, started on the same edge.
        e1 = model(16'h000F, 16'h000C, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h000F; b = 16'h000C; sub = 1'b0; sat = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d4 = -1; d1 = -1; d16 = -1;
        for (c = 0; c < 24; c++) begin
            if (bus4.done  && d4  < 0) d4  = c;
            if (bus1.done  && d1  < 0) d1  = c;
            if (bus16.done && d16 < 0) d16 = c;
            @(posedge clk); #1;
        end
        check("c4.latency",  32'(d4),  32'd4);
        check("c1.latency",  32'(d1),  32'd16);
        check("c16.latency", 32'(d16), 32'd1);
        check("c1.result",  32'(bus1.result),  32'h001B);
        check("c16.result", 32'(bus16.result), 32'h001B);
        check_res("c4", e1);

        do_op(16'h000F, 16'h000C, 1'b1, 1'b0, 1'b0, "sub_basic");
        do_op(16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, "sub_zero");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_wrap");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "ovf_nosat");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, "ovf_satpos");
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, "ovf_satneg");

        // Start during busy is dropped; start in the DONE cycle is taken.
        e1 = model(16'h1111, 16'h2222, 1'b0, 1'b0);
        e3 = model(16'h4000, 16'h0123, 1'b1, 1'b0);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; sat = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h0F0F; b = 16'h1234; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!bus4.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_start.latency", 32'(lat), 32'd4);
        check_res("busy_start", e1);
        a = 16'h4000; b = 16'h0123; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!bus4.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b.spacing", 32'(lat), 32'd5);
        check_res("b2b", e3);

        // Asynchronous abort on the second RUN cycle.
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (4) @(posedge clk);
        #1;
        check("abort.no_done", 32'(bus4.done), 32'h0);
        check("abort.no_busy", 32'(bus4.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, "after_reset");

        do_op(16'hA5A5, 16'h1234, 1'b1, 1'b0, 1'b1, "scramble_sub");
        do_op(16'h7000, 16'h1000, 1'b0, 1'b1, 1'b1, "scramble_sat");

        for (int i = 0; i < 40; i++) begin
            x = (i % 4 == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
            y = (i % 5 == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
            do_op(x, y, 1'($urandom), 1'($urandom), (i % 3) == 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
